// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle controller: FSM state
// encoding, opcode constants and the datapath select encodings.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } ctrl_state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;

endpackage

// File: rtl/imm_type_decode.sv
// Combinational opcode -> immediate-format select for the immediate generator.
module imm_type_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic [2:0] o_imm_src
);

  // R-type carries no immediate; I format is the harmless fallback.
  always_comb begin
    o_imm_src = IMM_I;
    case (i_opcode)
      OP_STORE:  o_imm_src = IMM_S;
      OP_BRANCH: o_imm_src = IMM_B;
      OP_JAL:    o_imm_src = IMM_J;
      default:   o_imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM with req/ready memory handshake.
// Define MULTICYCLE_CTRL_INSTRET_EN to build the retired-instruction counter.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [6:0]      opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_write,
  output logic            adr_src,
  output logic            ir_write,
  output logic            pc_write,
  output logic            reg_write,
  output logic [1:0]      alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      result_src,
  output logic [1:0]      alu_op,
  output logic [2:0]      imm_src,
  output logic            illegal,
  output logic [XLEN-1:0] instret
);

  ctrl_state_e r_state;
  ctrl_state_e w_next_state;
  logic [2:0]  w_imm_src;
  logic        r_illegal;

  imm_type_decode u_imm_type_decode (
    .i_opcode  (opcode),
    .o_imm_src (w_imm_src)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_DECODE && w_next_state == S_TRAP) begin
        r_illegal <= 1'b1;
      end
    end
  end

  // Outputs are forced low while reset is high, whatever state is held.
  always_comb begin
    w_next_state = r_state;
    mem_req      = 1'b0;
    mem_write    = 1'b0;
    adr_src      = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    reg_write    = 1'b0;
    alu_src_a    = SRC_A_PC;
    alu_src_b    = SRC_B_RS2;
    result_src   = RES_ALUOUT;
    alu_op       = ALU_OP_ADD;
    if (reset) begin
      w_next_state = S_FETCH;
    end else begin
      case (r_state)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = SRC_B_FOUR;
          result_src = RES_ALURES;
          if (mem_ready) begin
            ir_write     = 1'b1;
            pc_write     = 1'b1;
            w_next_state = S_DECODE;
          end else begin
            w_next_state = S_FETCH;
          end
        end
        S_DECODE: begin
          alu_src_a = SRC_A_OLDPC;
          alu_src_b = SRC_B_IMM;
          case (opcode)
            OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
            OP_RTYPE:          w_next_state = S_EXECR;
            OP_ITYPE:          w_next_state = S_EXECI;
            OP_BRANCH:         w_next_state = S_BEQ;
            OP_JAL:            w_next_state = S_JAL;
            default:           w_next_state = S_TRAP;
          endcase
        end
        S_MEMADR: begin
          alu_src_a    = SRC_A_RS1;
          alu_src_b    = SRC_B_IMM;
          w_next_state = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        end
        S_MEMREAD: begin
          mem_req      = 1'b1;
          adr_src      = 1'b1;
          w_next_state = mem_ready ? S_MEMWB : S_MEMREAD;
        end
        S_MEMWB: begin
          result_src   = RES_MEMDATA;
          reg_write    = 1'b1;
          w_next_state = S_FETCH;
        end
        S_MEMWRITE: begin
          mem_req      = 1'b1;
          mem_write    = 1'b1;
          adr_src      = 1'b1;
          w_next_state = mem_ready ? S_FETCH : S_MEMWRITE;
        end
        S_EXECR: begin
          alu_src_a    = SRC_A_RS1;
          alu_op       = ALU_OP_FUNCT;
          w_next_state = S_ALUWB;
        end
        S_EXECI: begin
          alu_src_a    = SRC_A_RS1;
          alu_src_b    = SRC_B_IMM;
          alu_op       = ALU_OP_FUNCT;
          w_next_state = S_ALUWB;
        end
        S_ALUWB: begin
          reg_write    = 1'b1;
          w_next_state = S_FETCH;
        end
        S_BEQ: begin
          alu_src_a    = SRC_A_RS1;
          alu_op       = ALU_OP_SUB;
          pc_write     = zero;
          w_next_state = S_FETCH;
        end
        S_JAL: begin
          // ALU forms the link value oldPC+4 while PC loads the target from ALUOut.
          alu_src_a    = SRC_A_OLDPC;
          alu_src_b    = SRC_B_FOUR;
          pc_write     = 1'b1;
          w_next_state = S_ALUWB;
        end
        S_TRAP: begin
          w_next_state = S_TRAP;
        end
        default: begin
          w_next_state = S_FETCH;
        end
      endcase
    end
  end

  assign imm_src = reset ? 3'b000 : w_imm_src;
  assign illegal = r_illegal & ~reset;

`ifdef MULTICYCLE_CTRL_INSTRET_EN
  logic [XLEN-1:0] r_instret;
  logic            w_retire;

  assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) || (r_state == S_BEQ) ||
                    ((r_state == S_MEMWRITE) && mem_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instret <= '0;
    end else if (w_retire) begin
      r_instret <= r_instret + {{(XLEN-1){1'b0}}, 1'b1};
    end
  end

  assign instret = reset ? '0 : r_instret;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl; instret expectations follow
// MULTICYCLE_CTRL_INSTRET_EN. A narrow XLEN makes the counter wrap reachable.
module tb_multicycle_ctrl;

  localparam int XLEN = 8;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] res;
    logic [1:0] aop;
    logic [2:0] imm;
    logic       ill;
  } ctrl_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [6:0]      opcode;
  logic            zero;
  logic            mem_ready;
  logic            mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]      alu_src_a, alu_src_b, result_src, alu_op;
  logic [2:0]      imm_src;
  logic            illegal;
  logic [XLEN-1:0] instret;

  int              n_assert = 0;
  int              n_fail   = 0;
  logic [XLEN-1:0] exp_instret = '0;
  ctrl_t           exp_q[$];
  string           tag_q[$];

  multicycle_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .alu_op(alu_op),
    .imm_src(imm_src), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  function automatic ctrl_t mk(input logic req, wr, adr, irw, pcw, rw,
                               input logic [1:0] sa, sb, rs, aop, input logic ill);
    ctrl_t c;
    c = '{req, wr, adr, irw, pcw, rw, sa, sb, rs, aop, 3'b000, ill};
    return c;
  endfunction

  function automatic ctrl_t e_rst();        return mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0); endfunction
  function automatic ctrl_t e_fetch(logic r); return mk(1,0,0,r,r,0,2'b00,2'b10,2'b10,2'b00,0); endfunction
  function automatic ctrl_t e_decode();     return mk(0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,0); endfunction
  function automatic ctrl_t e_memadr();     return mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,0); endfunction
  function automatic ctrl_t e_memread();    return mk(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0); endfunction
  function automatic ctrl_t e_memwb();      return mk(0,0,0,0,0,1,2'b00,2'b00,2'b01,2'b00,0); endfunction
  function automatic ctrl_t e_memwrite();   return mk(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0); endfunction
  function automatic ctrl_t e_execr();      return mk(0,0,0,0,0,0,2'b10,2'b00,2'b00,2'b10,0); endfunction
  function automatic ctrl_t e_execi();      return mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b10,0); endfunction
  function automatic ctrl_t e_aluwb();      return mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0); endfunction
  function automatic ctrl_t e_beq(logic z); return mk(0,0,0,0,z,0,2'b10,2'b00,2'b00,2'b01,0); endfunction
  function automatic ctrl_t e_jal();        return mk(0,0,0,0,1,0,2'b01,2'b10,2'b00,2'b00,0); endfunction
  function automatic ctrl_t e_trap();       return mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1); endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      default:    return 3'b000;
    endcase
  endfunction

  function automatic ctrl_t observed();
    return '{mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
             alu_src_a, alu_src_b, result_src, alu_op, imm_src, illegal};
  endfunction

  // One clock: queue the expectation, sample mid-cycle, compare, advance.
  task automatic step(input string tag, input ctrl_t e);
    ctrl_t exp_c;
    ctrl_t got;
    string t;
    exp_c = e;
    exp_c.imm = reset ? 3'b000 : imm_of(opcode);
    exp_q.push_back(exp_c);
    tag_q.push_back(tag);
    #1;
    got   = observed();
    exp_c = exp_q.pop_front();
    t     = tag_q.pop_front();
    n_assert++;
    assert (got === exp_c) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", t, got, exp_c);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_instret(input string tag);
    n_assert++;
    assert (instret === exp_instret) else begin
      n_fail++;
      $error("FAIL %s: instret observed %h expected %h", tag, instret, exp_instret);
    end
  endtask

  task automatic bump();
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    exp_instret = exp_instret + 8'd1;
`endif
  endtask

  task automatic run_add(input string t);
    opcode = 7'b0110011; mem_ready = 1'b1;
    step({t, "_fetch"}, e_fetch(1'b1));
    step({t, "_decode"}, e_decode());
    step({t, "_execr"}, e_execr());
    step({t, "_aluwb"}, e_aluwb());
    bump();
  endtask

  task automatic run_sw(input string t);
    opcode = 7'b0100011; mem_ready = 1'b1;
    step({t, "_fetch"}, e_fetch(1'b1));
    step({t, "_decode"}, e_decode());
    step({t, "_memadr"}, e_memadr());
    step({t, "_memwrite"}, e_memwrite());
    bump();
  endtask

  initial begin
    reset = 1'b1; opcode = 7'b0000000; zero = 1'b0; mem_ready = 1'b0;
    step("rst0", e_rst());
    step("rst1", e_rst());
    chk_instret("rst_instret");

    reset = 1'b0;
    run_add("add");
    chk_instret("add_instret");

    opcode = 7'b0010011; mem_ready = 1'b1;
    step("addi_fetch", e_fetch(1'b1));
    step("addi_decode", e_decode());
    step("addi_execi", e_execi());
    step("addi_aluwb", e_aluwb());
    bump();
    chk_instret("addi_instret");

    // Load with two wait cycles: seven cycles in total.
    opcode = 7'b0000011; mem_ready = 1'b1;
    step("lw_fetch", e_fetch(1'b1));
    step("lw_decode", e_decode());
    step("lw_memadr", e_memadr());
    mem_ready = 1'b0;
    step("lw_wait0", e_memread());
    step("lw_wait1", e_memread());
    mem_ready = 1'b1;
    step("lw_memread", e_memread());
    step("lw_memwb", e_memwb());
    bump();
    chk_instret("lw_instret");

    run_sw("sw");
    chk_instret("sw_instret");

    opcode = 7'b1100011; zero = 1'b1; mem_ready = 1'b0;
    step("beq1_fetchwait", e_fetch(1'b0));
    mem_ready = 1'b1;
    step("beq1_fetch", e_fetch(1'b1));
    step("beq1_decode", e_decode());
    step("beq1_beq", e_beq(1'b1));
    bump();
    chk_instret("beq1_instret");

    zero = 1'b0;
    step("beq0_fetch", e_fetch(1'b1));
    step("beq0_decode", e_decode());
    step("beq0_beq", e_beq(1'b0));
    bump();
    chk_instret("beq0_instret");

    opcode = 7'b1101111;
    step("jal_fetch", e_fetch(1'b1));
    step("jal_decode", e_decode());
    step("jal_jal", e_jal());
    step("jal_aluwb", e_aluwb());
    bump();
    chk_instret("jal_instret");

    opcode = 7'b1110011;
    step("trap_fetch", e_fetch(1'b1));
    step("trap_decode", e_decode());
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      step($sformatf("trap_hold%0d", i), e_trap());
    end
    chk_instret("trap_instret");
    reset = 1'b1;
    step("trap_rst", e_rst());
    exp_instret = '0;
    reset = 1'b0;
    run_add("post_trap");
    chk_instret("post_trap_instret");

    // Reset lands in the middle of a store wait.
    opcode = 7'b0100011; mem_ready = 1'b1;
    step("swr_fetch", e_fetch(1'b1));
    step("swr_decode", e_decode());
    step("swr_memadr", e_memadr());
    mem_ready = 1'b0;
    step("swr_wait0", e_memwrite());
    step("swr_wait1", e_memwrite());
    reset = 1'b1;
    step("swr_rst", e_rst());
    exp_instret = '0;
    reset = 1'b0;
    chk_instret("swr_instret");
    run_add("swr_next");

    for (int i = 0; i < 254; i++) begin
      run_sw($sformatf("fill%0d", i));
    end
    chk_instret("wrap_pre");
    run_sw("wrap_sw");
    chk_instret("wrap_post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
